shadow_chain_rx: RTL
====================

Name: shadow_chain_rx

Overview:
- Drain-side counterpart of the per-module shadow_capture blocks (CHAINS_OUT side).
- Freezes capture, asserts dump_en per chain, and deserialises the 1-bit chains (ch_out / ch_out_vld / ch_out_done) into WORD_W-bit words.
- Buffers words in a small FIFO and presents them to the debug host with valid/ready.
- Sits on sh_clk next to an EXU shadow-instrumented module such as the CCR file.

Parameters:
CHAINS, 2, number of serial chains received (matches CHAINS_OUT of the source)
WORD_W, 32, bits per output word
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
sh_clk  in  1  shadow/data clock; all logic on rising edge
sh_rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to dump; honoured only in IDLE
chain_mask  in  CHAINS  chains to dump, sampled with start
capture_en  out  1  to source c_en; =~busy
dump_en  out  CHAINS  to source dump_en; one-hot or zero
ch_in  in  CHAINS  serial chain data (source ch_out)
ch_in_vld  in  CHAINS  bit-valid per chain
ch_in_done  in  CHAINS  one-cycle end-of-chain pulse, no data
out_data  out  WORD_W  packed word, first-received bit at [0]
out_chain  out  clog2(CHAINS) max 1  chain index of word
out_last  out  1  final word of that chain
out_nbits  out  clog2(WORD_W)+1  valid bits in out_data
out_vld  out  1  FIFO head valid
out_rdy  in  1  host accepts head
busy  out  1  dump sequence in progress
dump_done  out  1  one-cycle pulse at sequence end
ovf_err  out  1  sticky: word dropped on full FIFO
err_clr  in  1  clears ovf_err

Behaviour:
- Reset: state IDLE; busy=0, capture_en=1, dump_en=0, out_vld=0, out_data/out_chain/out_last/out_nbits=0, dump_done=0, ovf_err=0; FIFO empty, bit_ptr=0, remaining mask=0. Reset mid-dump aborts immediately; FIFO contents are lost.
- States: IDLE, SEL, DUMP, FLUSH, DONE.
- IDLE: start & mask!=0 -> SEL next cycle, busy=1, rem=chain_mask. start & mask==0 -> DONE. start while busy is ignored.
- SEL: one cycle. Pick the lowest set bit of rem as idx. bit_ptr=0 -> DUMP.
- DUMP:
  - dump_en[idx]=1 unless FIFO free entries <2 (throttle). The source may still deliver one bit after deassertion; that bit is accepted.
  - ch_in_vld[idx]: bit written to word[bit_ptr], bit_ptr++.
  - When bit_ptr==WORD_W-1 on an accepted bit, push {word, idx, last=0, nbits=WORD_W} and set bit_ptr=0. If the FIFO is full and not popping in the same cycle, drop the word and set ovf_err.
  - ch_in_done[idx] -> FLUSH, dump_en=0. If vld and done arrive in the same cycle, take the bit first.
  - Activity on non-selected chains is ignored.
- FLUSH:
  - Push {word zero-padded, idx, last=1, nbits=bit_ptr}. If bit_ptr==0, push an all-zero word with nbits=0, last=1.
  - Stall in FLUSH while the FIFO is full; the terminator is never dropped.
  - Then clear rem[idx]. rem!=0 -> SEL, else -> DONE.
- DONE: dump_done=1 for one cycle, busy=0 next cycle -> IDLE. capture_en re-asserts with busy=0.
- FIFO:
  - Pop on out_vld & out_rdy.
  - Push accepted when full if a pop occurs the same cycle.
  - Outputs show the head entry. Zero-latency view: a push into an empty FIFO gives out_vld=1 the next cycle.
  - Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty.
- ovf_err: set dominates err_clr when both occur in the same cycle.

Decomposition:
- Package shadow_chain_rx_pkg: state enum (IDLE, SEL, DUMP, FLUSH, DONE); IDX_W and NB_W constants from CHAINS and WORD_W; FIFO entry struct {data, chain, last, nbits}.
- Sub-module shadow_chain_rx_fifo: sync FIFO with push/pop/full/empty/free_cnt, async active-high reset.

Test Plan:
- WORD_W=8, mask=2'b01, chain0 sends 16 bits 0xA5 then 0x3C, then done -> dump_en=2'b01; words {0xA5,ch0,last0,nb8}, {0x3C,ch0,last0,nb8}, {0x00,ch0,last1,nb0}; dump_done pulse; capture_en low throughout the dump.
- WORD_W=8, mask=2'b11, chain0 5 bits 10110 (first bit =1), chain1 3 bits -> {0x0D,ch0,last1,nb5}, then dump_en=2'b10, {chain1 bits,ch1,last1,nb3}; chain0 fully drained before chain1 selected.
- out_rdy=0, FIFO_DEPTH=4, 40 bits streamed -> dump_en drops at 3 words buffered; the source stops, no drop, ovf_err=0; raising out_rdy resumes and all 5 full words plus terminator arrive in order.
- Source ignores dump_en (keeps shifting) with out_rdy=0 -> fifth full word dropped, ovf_err=1; FLUSH stalls until a pop; err_clr with no new overflow -> ovf_err=0.
- start with mask=0 -> dump_done next-but-one cycle, no dump_en, no words; start pulsed during DUMP -> no effect; vld and done in the same cycle -> bit counted in nbits.
- sh_rst asserted mid-DUMP -> next edge: dump_en=0, busy=0, capture_en=1, out_vld=0, ovf_err=0.

Source files
------------

// File: rtl/shadow_chain_rx_pkg.sv
// Shared types and width helpers for the shadow chain drain receiver.
package shadow_chain_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    DUMP,
    FLUSH,
    DONE
  } state_t;

  function automatic int calc_idx_w(input int chains);
    return (chains > 1) ? $clog2(chains) : 1;
  endfunction

  function automatic int calc_nb_w(input int word_w);
    return $clog2(word_w) + 1;
  endfunction

endpackage

// File: rtl/shadow_chain_rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible combinationally, zeros when empty.
module shadow_chain_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_free_cnt
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  w_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop   = i_pop & ~o_empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign o_free_cnt = (AW+1)'(DEPTH) - w_count;
  assign o_dout     = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/shadow_chain_rx.sv
// Drains shadow capture chains one at a time, packing serial bits into words for the debug host.
// Capture is frozen while a dump runs; the chain is throttled when fewer than two FIFO slots remain.
module shadow_chain_rx
  import shadow_chain_rx_pkg::*;
#(
  parameter int CHAINS     = 2,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = calc_idx_w(CHAINS),
  localparam int NB_W      = calc_nb_w(WORD_W)
) (
  input  logic              i_sh_clk,
  input  logic              i_sh_rst,
  input  logic              i_start,
  input  logic [CHAINS-1:0] i_chain_mask,
  output logic              o_capture_en,
  output logic [CHAINS-1:0] o_dump_en,
  input  logic [CHAINS-1:0] i_ch_in,
  input  logic [CHAINS-1:0] i_ch_in_vld,
  input  logic [CHAINS-1:0] i_ch_in_done,
  output logic [WORD_W-1:0] o_out_data,
  output logic [IDX_W-1:0]  o_out_chain,
  output logic              o_out_last,
  output logic [NB_W-1:0]   o_out_nbits,
  output logic              o_out_vld,
  input  logic              i_out_rdy,
  output logic              o_busy,
  output logic              o_dump_done,
  output logic              o_ovf_err,
  input  logic              i_err_clr
);

  localparam int PTR_W = $clog2(WORD_W);
  localparam int FA_W  = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [IDX_W-1:0]  chain;
    logic              last;
    logic [NB_W-1:0]   nbits;
  } entry_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CHAINS-1:0] r_rem;
  logic [CHAINS-1:0] w_rem_clr;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_low_idx;
  logic [PTR_W-1:0]  r_bit_ptr;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_nx;
  logic              r_ovf;
  logic              w_bit_acc;
  logic              w_word_full;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [FA_W:0]     w_free;
  entry_t            w_push_ent;
  entry_t            w_head;

  always_comb begin
    w_low_idx = '0;
    for (int i = CHAINS - 1; i >= 0; i--) begin
      if (r_rem[i]) w_low_idx = IDX_W'(i);
    end
  end

  assign w_rem_clr   = r_rem & ~(CHAINS'(1) << r_idx);
  assign w_pop       = ~w_empty & i_out_rdy;
  assign w_bit_acc   = (r_state == DUMP) & i_ch_in_vld[r_idx];
  assign w_word_full = w_bit_acc & (r_bit_ptr == PTR_W'(WORD_W - 1));

  always_comb begin
    w_word_nx = r_word;
    if (w_bit_acc) w_word_nx[r_bit_ptr] = i_ch_in[r_idx];
  end

  always_comb begin
    w_state_nx = r_state;
    w_push     = 1'b0;
    w_drop     = 1'b0;
    w_push_ent = '0;
    o_dump_en  = '0;
    case (r_state)
      IDLE:  if (i_start) w_state_nx = (|i_chain_mask) ? SEL : DONE;
      SEL:   w_state_nx = DUMP;
      DUMP: begin
        if (w_free > (FA_W+1)'(1)) o_dump_en[r_idx] = 1'b1;
        if (w_word_full) begin
          w_push_ent = '{data: w_word_nx, chain: r_idx, last: 1'b0, nbits: NB_W'(WORD_W)};
          if (~w_full | w_pop) w_push = 1'b1;
          else                 w_drop = 1'b1;
        end
        if (i_ch_in_done[r_idx]) w_state_nx = FLUSH;
      end
      FLUSH: begin
        // The terminator waits for space rather than being dropped.
        w_push_ent = '{data: r_word, chain: r_idx, last: 1'b1, nbits: NB_W'(r_bit_ptr)};
        if (~w_full | w_pop) begin
          w_push     = 1'b1;
          w_state_nx = (|w_rem_clr) ? SEL : DONE;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_sh_clk or posedge i_sh_rst) begin
    if (i_sh_rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_idx     <= '0;
      r_bit_ptr <= '0;
      r_word    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && i_start && |i_chain_mask) r_rem <= i_chain_mask;
      if (r_state == SEL) begin
        r_idx     <= w_low_idx;
        r_bit_ptr <= '0;
        r_word    <= '0;
      end
      if (w_bit_acc) begin
        if (w_word_full) begin
          r_bit_ptr <= '0;
          r_word    <= '0;
        end else begin
          r_bit_ptr <= r_bit_ptr + PTR_W'(1);
          r_word    <= w_word_nx;
        end
      end
      if (r_state == FLUSH && w_push) r_rem <= w_rem_clr;
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_err_clr) r_ovf <= 1'b0;
    end
  end

  shadow_chain_rx_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_sh_clk),
    .i_rst      (i_sh_rst),
    .i_push     (w_push),
    .i_din      (w_push_ent),
    .i_pop      (w_pop),
    .o_dout     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_free_cnt (w_free)
  );

  assign o_busy       = (r_state != IDLE);
  assign o_capture_en = ~o_busy;
  assign o_dump_done  = (r_state == DONE);
  assign o_ovf_err    = r_ovf;
  assign o_out_vld    = ~w_empty;
  assign o_out_data   = w_head.data;
  assign o_out_chain  = w_head.chain;
  assign o_out_last   = w_head.last;
  assign o_out_nbits  = w_head.nbits;

endmodule
